count_sample_fifo: RTL and testbench
====================================

COUNT_SAMPLE_FIFO -- requirements
Module: count_sample_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter CW, default 4, sampled count width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port count_in  input  CW  free-running counter value to sample.
REQ-006 SHALL have port sample_en  input  1  request to capture count_in this cycle.
REQ-007 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-008 SHALL have port clear_ovf  input  1  clears sticky overflow.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_data  output  CW  head entry count value.
REQ-011 SHALL have port out_wrap  output  1  head entry was captured after a counter wrap.
REQ-012 SHALL have port level  output  log2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port full, empty  output  1 each  occupancy == DEPTH / == 0.
REQ-014 SHALL have port overflow  output  1  sticky flag: a sample was dropped.

Function
REQ-015 SHALL store entries of {wrap, count} (CW+1 bits) in a DEPTH-entry circular buffer with read and write pointers.
REQ-016 SHALL define pop = out_valid && out_ready, and push = sample_en && (!full || pop).
REQ-017 SHALL, on push, write {wrap_calc, count_in} at the write pointer; pointer wraps from DEPTH-1 to 0.
REQ-018 SHALL, on pop, advance the read pointer; pointer wraps from DEPTH-1 to 0.
REQ-019 SHALL compute wrap_calc = prev_valid && (count_in < prev_count); prev_count/prev_valid update only on push.
REQ-020 SHALL drive out_valid = !empty; out_data/out_wrap = head entry; no fall-through (a sample pushed into an empty FIFO is valid the next cycle).
REQ-021 SHALL hold out_data/out_wrap stable while out_valid && !out_ready.
REQ-022 SHALL update level +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-023 SHALL, when full and pop in the same cycle, accept the sample; level stays DEPTH.
REQ-024 SHALL, when sample_en && full && !pop, drop the sample, leave pointers/prev_count unchanged, and set overflow next cycle.
REQ-025 SHALL clear overflow on clear_ovf; if a drop and clear_ovf coincide, overflow remains set.
REQ-026 SHALL ignore out_ready while empty (no pointer movement, level stays 0).
REQ-027 SHALL tolerate simultaneous push and pop when empty: not possible (pop requires out_valid), so push alone occurs.

Reset
REQ-028 SHALL, on reset assertion, immediately clear pointers, level=0, empty=1, full=0, out_valid=0, overflow=0, prev_valid=0, prev_count=0.
REQ-029 SHALL drive out_data=0 and out_wrap=0 during and after reset until the first push is visible.
REQ-030 SHALL discard all stored entries if reset asserts mid-operation; first sample after reset has wrap=0.

Verification
REQ-031 Reset then sample_en for 3 cycles with count_in 5,6,7, out_ready=0 -> level=3, out_data=5, out_wrap=0, out_valid one cycle after first sample.
REQ-032 Samples 14,15,0,1 then drain -> out_data 14,15,0,1 with out_wrap 0,0,1,0.
REQ-033 Fill 8 entries, out_ready=0, sample_en with count_in=9 -> full=1, level=8, overflow=1 next cycle, entry 9 never read; clear_ovf -> overflow=0.
REQ-034 Full FIFO, sample_en and out_ready same cycle -> level stays 8, oldest popped, new sample at tail, overflow stays 0.
REQ-035 Continuous sample_en and out_ready=1 for 20 cycles on a 0..15 counter -> level oscillates 0..1, every value read in order, pointers wrap correctly.
REQ-036 Reset asserted asynchronously with level=5 -> level=0, empty=1, out_valid=0 before next clk edge; next sample has out_wrap=0.

Source files
------------

// File: rtl/count_sample_fifo.sv
// Captures a free-running counter on request into a small FIFO, tagging each
// sample with whether the counter wrapped since the previously stored sample.
module count_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CW-1:0]            count_in,
  input  logic                     sample_en,
  input  logic                     out_ready,
  input  logic                     clear_ovf,
  output logic                     out_valid,
  output logic [CW-1:0]            out_data,
  output logic                     out_wrap,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [CW:0]    mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [AW:0]    lvl;
  logic [CW-1:0]  prev_count;
  logic           prev_valid;
  logic           push;
  logic           pop;
  logic           drop;
  logic           wrap_calc;
  logic [CW:0]    head;

  assign empty     = (lvl == '0);
  assign full      = (lvl == FULL_LVL);
  assign level     = lvl;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign push      = sample_en && (!full || pop);
  assign drop      = sample_en && full && !pop;
  assign wrap_calc = prev_valid && (count_in < prev_count);

  // Head is masked while empty so stale or uninitialised storage never shows.
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[CW-1:0] : '0;
  assign out_wrap  = out_valid && head[CW];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {wrap_calc, count_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      lvl        <= '0;
      prev_count <= '0;
      prev_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        prev_count <= count_in;
        prev_valid <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
      // A drop in the same cycle as a clear wins, so no loss goes unreported.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_count_sample_fifo.sv
// Directed bench for count_sample_fifo (DEPTH=8, CW=4) with hand-computed expectations.
module tb_count_sample_fifo;

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic       sample_en;
  logic       out_ready;
  logic       clear_ovf;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_wrap;
  logic [3:0] level;
  logic       full;
  logic       empty;
  logic       overflow;

  int compared;
  int mismatched;

  count_sample_fifo #(.DEPTH(8), .CW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .sample_en (sample_en),
    .out_ready (out_ready),
    .clear_ovf (clear_ovf),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_wrap  (out_wrap),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_d [4];
    logic       exp_w [4];
    logic [3:0] seq_v;
    logic [3:0] prev_v;

    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    count_in   = '0;
    sample_en  = 1'b0;
    out_ready  = 1'b0;
    clear_ovf  = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", out_data, 0);
    chk("rst_wrap", out_wrap, 0);
    tick();
    reset = 1'b0;

    // Three samples 5,6,7 with consumer stalled; no fall-through.
    sample_en = 1'b1;
    count_in  = 4'd5;
    chk("nofall_valid", out_valid, 0);
    tick();
    chk("first_valid", out_valid, 1);
    chk("first_data", out_data, 5);
    chk("first_level", level, 1);
    count_in = 4'd6;
    tick();
    count_in = 4'd7;
    tick();
    sample_en = 1'b0;
    chk("three_level", level, 3);
    chk("three_data", out_data, 5);
    chk("three_wrap", out_wrap, 0);
    tick();
    chk("stall_data", out_data, 5);

    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("drain1_data", out_data, 5 + i);
      tick();
    end
    chk("drain1_empty", empty, 1);
    tick();
    chk("idle_ready_level", level, 0);
    out_ready = 1'b0;

    // Wrap tagging across 15 -> 0.
    exp_d[0] = 4'd14; exp_w[0] = 1'b0;
    exp_d[1] = 4'd15; exp_w[1] = 1'b0;
    exp_d[2] = 4'd0;  exp_w[2] = 1'b1;
    exp_d[3] = 4'd1;  exp_w[3] = 1'b0;
    sample_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      count_in = exp_d[i];
      tick();
    end
    sample_en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("wrapseq_data", out_data, exp_d[i]);
      chk("wrapseq_wrap", out_wrap, exp_w[i]);
      tick();
    end
    out_ready = 1'b0;

    // Fill with 1..8, then overflow attempts.
    sample_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      count_in = 4'(i);
      tick();
    end
    chk("fill_full", full, 1);
    chk("fill_level", level, 8);
    chk("fill_ovf_pre", overflow, 0);
    count_in = 4'd9;
    tick();
    chk("drop_ovf", overflow, 1);
    chk("drop_level", level, 8);
    count_in  = 4'd10;
    clear_ovf = 1'b1;
    tick();
    chk("drop_clear_ovf", overflow, 1);
    sample_en = 1'b0;
    tick();
    chk("clear_ovf", overflow, 0);
    clear_ovf = 1'b0;

    // Full with simultaneous push and pop.
    sample_en = 1'b1;
    out_ready = 1'b1;
    count_in  = 4'd11;
    tick();
    sample_en = 1'b0;
    out_ready = 1'b0;
    chk("fullpp_level", level, 8);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_head", out_data, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain2_data", out_data, (i < 7) ? 2 + i : 11);
      chk("drain2_wrap", out_wrap, 0);
      tick();
    end
    chk("drain2_empty", empty, 1);

    // Streaming: 20 cycles of sample and pop, counter 12..15,0..15.
    prev_v    = 4'd11;
    sample_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      seq_v    = 4'((12 + i) % 16);
      count_in = seq_v;
      tick();
      chk("stream_level", level, 1);
      chk("stream_data", out_data, seq_v);
      chk("stream_wrap", out_wrap, (seq_v < prev_v) ? 1 : 0);
      prev_v = seq_v;
    end
    sample_en = 1'b0;
    tick();
    chk("stream_end_level", level, 0);
    out_ready = 1'b0;

    // Asynchronous reset with five entries stored.
    sample_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      count_in = 4'(3 + i);
      tick();
    end
    sample_en = 1'b0;
    chk("pre_arst_level", level, 5);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    tick();
    reset     = 1'b0;
    sample_en = 1'b1;
    count_in  = 4'd0;
    tick();
    sample_en = 1'b0;
    chk("post_arst_valid", out_valid, 1);
    chk("post_arst_data", out_data, 0);
    chk("post_arst_wrap", out_wrap, 0);
    chk("post_arst_level", level, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
